onchip_ram_dp_pipelined: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) on one clock. It generalises the single-port on-chip memory: configurable data width, depth and read latency, explicit read handshake with readdatavalid, and a defined collision policy. It sits on the system interconnect as program/data memory shared by a CPU and a DMA or accelerator master.

---
 rtl/onchip_ram_dp_pipelined.sv | 157 +++++++++++++++
 tb/tb_onchip_ram_dp_pipelined.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_dp_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_ram_dp_pipelined
//  Description : True-dual-port on-chip RAM with two Avalon-MM slave ports
//                (s1, s2) sharing a single clock. Reads are pipelined and
//                qualified by readdatavalid. Writes are byte-lane masked.
//                When both ports write the same word in the same cycle, s1
//                wins on each byte lane that both ports enable.
//
//  Ports       : clk, reset (sync, active-high), clken (global enable)
//                sN_address / sN_chipselect / sN_read / sN_write
//                sN_byteenable / sN_writedata       -> request inputs
//                sN_readdata / sN_readdatavalid     -> read response outputs
//
//  Config      : `define ONCHIP_RAM_OUTREG_EN adds an output register stage
//                on both ports. Read latency then becomes 2 instead of 1.
//                INIT_FILE names the memory image that the implementation
//                flow loads. An empty string leaves the memory uninitialised.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module onchip_ram_dp_pipelined #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 15,
    parameter string INIT_FILE = "onchip_ram_dp.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,

    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid
);

    localparam int c_NUM_LANES = DATA_W / 8;
    localparam int c_NUM_PORTS = 2;

    // Memory image loaded by the implementation flow from INIT_FILE.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] r_mem [(1 << ADDR_W)];

    // Port-indexed views of the two slave interfaces (index 0 = s1, 1 = s2).
    logic [ADDR_W-1:0]      w_addr  [c_NUM_PORTS];
    logic [c_NUM_LANES-1:0] w_be    [c_NUM_PORTS];
    logic [DATA_W-1:0]      w_wdata [c_NUM_PORTS];
    logic [DATA_W-1:0]      w_rdata [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0] w_accept;
    logic [c_NUM_PORTS-1:0] w_wr;
    logic [c_NUM_PORTS-1:0] w_rd;
    logic [c_NUM_PORTS-1:0] w_rvalid;

    assign w_addr[0]  = s1_address;
    assign w_addr[1]  = s2_address;
    assign w_be[0]    = s1_byteenable;
    assign w_be[1]    = s2_byteenable;
    assign w_wdata[0] = s1_writedata;
    assign w_wdata[1] = s2_writedata;

    // Requests seen while in reset or while stalled are simply ignored.
    assign w_accept = {s2_chipselect, s1_chipselect} & {c_NUM_PORTS{clken & ~reset}};
    assign w_wr     = w_accept & {s2_write, s1_write};
    // A combined read+write on one port performs only the write.
    assign w_rd     = w_accept & {s2_read, s1_read} & ~{s2_write, s1_write};

    // ------------------------------------------------------------------------
    // Memory array. Memory contents are never reset. Port 2 lanes are
    // written first, so that a port 1 write to the same lane lands last.
    // Port 1 therefore wins on each lane that both ports enable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int p = c_NUM_PORTS - 1; p >= 0; p--) begin
            for (int b = 0; b < c_NUM_LANES; b++) begin
                if (w_wr[p] && w_be[p][b]) begin
                    r_mem[w_addr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-port read pipeline.
    // Stage p1 samples the array at the accepting edge. Because of that, a
    // same-cycle write from the other port is not yet visible, and the read
    // returns the old data. Stage p2 (plus p3 with the output register)
    // presents the result. Data registers load only behind a valid beat, so
    // readdata keeps its last value between responses.
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
        logic              r_vld_p1;
        logic              r_vld_p2;
        logic [DATA_W-1:0] r_data_p1;
        logic [DATA_W-1:0] r_data_p2;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld_p1  <= 1'b0;
                r_vld_p2  <= 1'b0;
                r_data_p1 <= '0;
                r_data_p2 <= '0;
            end else if (clken) begin
                r_vld_p1 <= w_rd[p];
                if (w_rd[p]) begin
                    r_data_p1 <= r_mem[w_addr[p]];
                end
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_data_p2 <= r_data_p1;
                end
            end
        end

`ifdef ONCHIP_RAM_OUTREG_EN
        logic              r_vld_p3;
        logic [DATA_W-1:0] r_data_p3;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld_p3  <= 1'b0;
                r_data_p3 <= '0;
            end else if (clken) begin
                r_vld_p3 <= r_vld_p2;
                if (r_vld_p2) begin
                    r_data_p3 <= r_data_p2;
                end
            end
        end

        assign w_rvalid[p] = r_vld_p3;
        assign w_rdata[p]  = r_data_p3;
`else
        assign w_rvalid[p] = r_vld_p2;
        assign w_rdata[p]  = r_data_p2;
`endif
    end

    assign s1_readdata      = w_rdata[0];
    assign s1_readdatavalid = w_rvalid[0];
    assign s2_readdata      = w_rdata[1];
    assign s2_readdatavalid = w_rvalid[1];

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_dp_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onchip_ram_dp_pipelined
//  Description : Self-checking bench for onchip_ram_dp_pipelined. A
//                word/byte-level memory model and per-port response queues
//                predict readdatavalid/readdata for every cycle. Directed
//                scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_ram_dp_pipelined;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 15;
    localparam int NB     = DATA_W / 8;
`ifdef ONCHIP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              clken;
    logic [ADDR_W-1:0] s1_address, s2_address;
    logic              s1_chipselect, s2_chipselect;
    logic              s1_read, s2_read, s1_write, s2_write;
    logic [NB-1:0]     s1_byteenable, s2_byteenable;
    logic [DATA_W-1:0] s1_writedata, s2_writedata;
    logic [DATA_W-1:0] s1_readdata, s2_readdata;
    logic              s1_readdatavalid, s2_readdatavalid;

    always #5 clk = ~clk;

    onchip_ram_dp_pipelined #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_FILE("")
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clken            (clken),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A read is answered LAT enabled edges after it is
    // accepted. Bytes never written are tracked as unknown and are not
    // compared.
    // ------------------------------------------------------------------
    typedef struct packed {
        int                due;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } rd_t;

    logic [DATA_W-1:0] m_mem   [int];
    logic [DATA_W-1:0] m_known [int];
    rd_t               q0[$];
    rd_t               q1[$];
    int                en_cnt = 0;
    logic              exp_v [2];
    logic [DATA_W-1:0] exp_d [2];
    logic [DATA_W-1:0] exp_m [2];

    logic              m_cs [2], m_rd [2], m_wr [2];
    int                m_a  [2];
    logic [NB-1:0]     m_be [2];
    logic [DATA_W-1:0] m_wd [2];

    function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = {8{be[b]}};
        return r;
    endfunction

    always @(posedge clk) begin : model
        rd_t               e;
        logic [DATA_W-1:0] lm, old, kn;
        m_cs[0] = s1_chipselect; m_rd[0] = s1_read; m_wr[0] = s1_write;
        m_a[0]  = int'(s1_address); m_be[0] = s1_byteenable; m_wd[0] = s1_writedata;
        m_cs[1] = s2_chipselect; m_rd[1] = s2_read; m_wr[1] = s2_write;
        m_a[1]  = int'(s2_address); m_be[1] = s2_byteenable; m_wd[1] = s2_writedata;
        if (reset) begin
            q0.delete();
            q1.delete();
            for (int p = 0; p < 2; p++) begin
                exp_v[p] = 1'b0; exp_d[p] = '0; exp_m[p] = '1;
            end
        end else if (clken) begin
            en_cnt++;
            exp_v[0] = 1'b0;
            exp_v[1] = 1'b0;
            if (q0.size() > 0 && q0[0].due == en_cnt) begin
                e = q0.pop_front();
                exp_v[0] = 1'b1; exp_d[0] = e.data; exp_m[0] = e.mask;
            end
            if (q1.size() > 0 && q1[0].due == en_cnt) begin
                e = q1.pop_front();
                exp_v[1] = 1'b1; exp_d[1] = e.data; exp_m[1] = e.mask;
            end
            // Reads see memory before this edge's writes.
            for (int p = 0; p < 2; p++) begin
                if (m_cs[p] && m_rd[p] && !m_wr[p]) begin
                    e.due  = en_cnt + LAT;
                    e.data = m_mem.exists(m_a[p])   ? m_mem[m_a[p]]   : '0;
                    e.mask = m_known.exists(m_a[p]) ? m_known[m_a[p]] : '0;
                    if (p == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            // s2 applied first, so that s1 overrides it on shared lanes.
            for (int p = 1; p >= 0; p--) begin
                if (m_cs[p] && m_wr[p]) begin
                    lm  = lane_mask(m_be[p]);
                    old = m_mem.exists(m_a[p])   ? m_mem[m_a[p]]   : '0;
                    kn  = m_known.exists(m_a[p]) ? m_known[m_a[p]] : '0;
                    m_mem[m_a[p]]   = (old & ~lm) | (m_wd[p] & lm);
                    m_known[m_a[p]] = kn | lm;
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s1_valid", {31'b0, s1_readdatavalid}, {31'b0, exp_v[0]});
            chk("s2_valid", {31'b0, s2_readdatavalid}, {31'b0, exp_v[1]});
            if (exp_v[0] && exp_m[0] != '0)
                chk("s1_rdata", s1_readdata & exp_m[0], exp_d[0] & exp_m[0]);
            if (exp_v[1] && exp_m[1] != '0)
                chk("s2_rdata", s2_readdata & exp_m[1], exp_d[1] & exp_m[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic drive(input int p, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [NB-1:0] be, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
        end else begin
            s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic get_v(input int p);
        return (p == 0) ? s1_readdatavalid : s2_readdatavalid;
    endfunction

    function automatic logic [DATA_W-1:0] get_d(input int p);
        return (p == 0) ? s1_readdata : s2_readdata;
    endfunction

    task automatic wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        idle(); drive(p, 1'b0, 1'b1, a, be, d); step(); idle();
    endtask

    task automatic wait_lit(input int p, input logic [DATA_W-1:0] lit, input int lat, input string name);
        bit seen = 1'b0;
        for (int n = 1; n <= lat + 8 && !seen; n++) begin
            step();
            if (get_v(p)) begin
                seen = 1'b1;
                chk({name, "_latency"}, n, lat);
                chk({name, "_data"}, get_d(p), lit);
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: readdatavalid never seen, expected after %0d cycles", name, lat);
        end
    endtask

    task automatic read_lit(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] lit, input string name);
        idle(); drive(p, 1'b1, 1'b0, a, '0, '0); step(); idle();
        wait_lit(p, lit, LAT, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        logic [DATA_W-1:0] got [8];
        int cnt;
        int vcnt;

        reset = 1'b1; clken = 1'b1; idle();
        // Requests during reset must be ignored.
        drive(0, 1'b1, 1'b0, 15'h0010, '0, '0);
        drive(1, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h5555_AAAA);
        step(); step();
        chk_en = 1'b1;
        step();
        chk("reset_s1_valid", {31'b0, s1_readdatavalid}, 32'd0);
        chk("reset_s2_valid", {31'b0, s2_readdatavalid}, 32'd0);
        chk("reset_s1_rdata", s1_readdata, 32'd0);
        chk("reset_s2_rdata", s2_readdata, 32'd0);
        idle(); reset = 1'b0; step();
        chk("post_reset_s1_valid", {31'b0, s1_readdatavalid}, 32'd0);

        // 1: basic write/read
        wr(0, 15'h0010, 32'hDEAD_BEEF, 4'hF);
        read_lit(0, 15'h0010, 32'hDEAD_BEEF, "t1_read");

        // 2: byte lanes at the top address
        wr(0, 15'h7FFF, 32'h1122_3344, 4'hF);
        wr(0, 15'h7FFF, 32'hAABB_CCDD, 4'h5);
        read_lit(1, 15'h7FFF, 32'h11BB_33DD, "t2_lanes");

        // 3: back-to-back s2 reads
        for (int i = 0; i < 8; i++) wr(0, ADDR_W'(i), DATA_W'(i * 3), 4'hF);
        cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    idle(); drive(1, 1'b1, 1'b0, ADDR_W'(i), '0, '0); step();
                end
                idle();
            end
            begin
                repeat (8 + LAT + 4) begin
                    step();
                    if (s2_readdatavalid && cnt < 8) begin
                        got[cnt] = s2_readdata;
                        cnt++;
                    end
                end
            end
        join
        chk("t3_pulse_count", cnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_data%0d", i), got[i], DATA_W'(i * 3));

        // 4: same-cycle collisions
        idle();
        drive(0, 1'b0, 1'b1, 15'h0100, 4'h3, 32'h0000_FFFF);
        drive(1, 1'b0, 1'b1, 15'h0100, 4'hF, 32'h1234_5678);
        step(); idle();
        read_lit(0, 15'h0100, 32'h1234_FFFF, "t4_ww");
        drive(0, 1'b0, 1'b1, 15'h0100, 4'hF, 32'hCAFE_F00D);
        drive(1, 1'b1, 1'b0, 15'h0100, '0, '0);
        step(); idle();
        wait_lit(1, 32'h1234_FFFF, LAT, "t4_wr_old");
        read_lit(1, 15'h0100, 32'hCAFE_F00D, "t4_new");

        // 5: reset flushes an in-flight read; memory survives
        idle(); drive(0, 1'b1, 1'b0, 15'h0010, '0, '0); step();
        vcnt = 0;
        if (s1_readdatavalid) vcnt++;
        idle(); reset = 1'b1;
        drive(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'h0);
        step();
        if (s1_readdatavalid) vcnt++;
        step();
        if (s1_readdatavalid) vcnt++;
        chk("t5_rdata_zero", s1_readdata, 32'd0);
        idle(); reset = 1'b0;
        repeat (4) begin
            step();
            if (s1_readdatavalid) vcnt++;
        end
        chk("t5_flushed", vcnt, 0);
        read_lit(0, 15'h0010, 32'hDEAD_BEEF, "t5_mem_kept");

        // 6: clken stalls
        idle(); drive(0, 1'b1, 1'b0, 15'h7FFF, '0, '0); step(); idle();
        wait_lit(0, 32'h11BB_33DD, LAT, "t6_read");
        clken = 1'b0;
        drive(0, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_hold_valid%0d", i), {31'b0, s1_readdatavalid}, 32'd1);
            chk($sformatf("t6_hold_data%0d", i), s1_readdata, 32'h11BB_33DD);
        end
        idle(); clken = 1'b1; step();
        chk("t6_valid_drop", {31'b0, s1_readdatavalid}, 32'd0);
        read_lit(0, 15'h7FFF, 32'h11BB_33DD, "t6_mem_unchanged");
        // A stall in the middle of the pipeline
        drive(1, 1'b1, 1'b0, 15'h0003, '0, '0); step(); idle();
        clken = 1'b0; step(); step(); step(); clken = 1'b1;
        wait_lit(1, 32'd9, LAT, "t6_midstall");

        // Randomised traffic, with the model checking every cycle
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            clken = ($urandom_range(0, 9) != 0);
            s1_chipselect = ($urandom_range(0, 3) != 0);
            s1_read       = $urandom_range(0, 1) == 1;
            s1_write      = ($urandom_range(0, 2) == 0);
            s1_address    = ADDR_W'($urandom_range(0, 15));
            s1_byteenable = NB'($urandom);
            s1_writedata  = $urandom;
            s2_chipselect = ($urandom_range(0, 3) != 0);
            s2_read       = $urandom_range(0, 1) == 1;
            s2_write      = ($urandom_range(0, 2) == 0);
            s2_address    = ADDR_W'($urandom_range(0, 15));
            s2_byteenable = NB'($urandom);
            s2_writedata  = $urandom;
            step();
        end
        reset = 1'b0; clken = 1'b1; idle();
        repeat (LAT + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
